// File: rtl/sha2_pkg.sv
// rtl/sha2_pkg.sv - shared types, schedule lengths and small-sigma constants for the SHA-2 message schedule
package sha2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EMIT
    } state_t;

    localparam int ROUNDS_256_DEF = 64;
    localparam int ROUNDS_512_DEF = 80;

    localparam int S0_R1_32 = 7;
    localparam int S0_R2_32 = 18;
    localparam int S0_SH_32 = 3;
    localparam int S1_R1_32 = 17;
    localparam int S1_R2_32 = 19;
    localparam int S1_SH_32 = 10;

    localparam int S0_R1_64 = 1;
    localparam int S0_R2_64 = 8;
    localparam int S0_SH_64 = 7;
    localparam int S1_R1_64 = 19;
    localparam int S1_R2_64 = 61;
    localparam int S1_SH_64 = 6;

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/sha2_small_sigma.sv
// rtl/sha2_small_sigma.sv - combinational small-sigma (sigma0 or sigma1 by parameter) for 32/64-bit words
module sha2_small_sigma
    import sha2_pkg::*;
#(
    parameter bit SIGMA1 = 1'b0
) (
    input  logic        i_mode,
    input  logic [63:0] i_x,
    output logic [63:0] o_y
);

    localparam int R1_32 = SIGMA1 ? S1_R1_32 : S0_R1_32;
    localparam int R2_32 = SIGMA1 ? S1_R2_32 : S0_R2_32;
    localparam int SH_32 = SIGMA1 ? S1_SH_32 : S0_SH_32;
    localparam int R1_64 = SIGMA1 ? S1_R1_64 : S0_R1_64;
    localparam int R2_64 = SIGMA1 ? S1_R2_64 : S0_R2_64;
    localparam int SH_64 = SIGMA1 ? S1_SH_64 : S0_SH_64;

    logic [31:0] w_y32;
    logic [63:0] w_y64;

    assign w_y32 = rotr32(i_x[31:0], R1_32) ^ rotr32(i_x[31:0], R2_32) ^ (i_x[31:0] >> SH_32);
    assign w_y64 = rotr64(i_x, R1_64) ^ rotr64(i_x, R2_64) ^ (i_x >> SH_64);
    assign o_y   = i_mode ? w_y64 : {32'h0, w_y32};

endmodule

// File: rtl/sha2_msg_sched.sv
// rtl/sha2_msg_sched.sv - SHA-256/512 message schedule controller; SHA2_SCHED_PERF_EN adds a stall counter
module sha2_msg_sched
    import sha2_pkg::*;
#(
    parameter int ROUNDS_256 = ROUNDS_256_DEF,
    parameter int ROUNDS_512 = ROUNDS_512_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_width_flag,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [6:0]  out_index,
    output logic        out_last,
    output logic        busy
`ifdef SHA2_SCHED_PERF_EN
    ,
    output logic [31:0] stall_count
`endif
);

    localparam logic [6:0] LAST_256 = 7'(ROUNDS_256 - 1);
    localparam logic [6:0] LAST_512 = 7'(ROUNDS_512 - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [6:0]  r_t;
    logic        r_mode;
    logic        r_in_ready;
    logic [63:0] r_buf [16];

    logic        w_emit;
    logic        w_in_fire;
    logic        w_out_fire;
    logic        w_mode_in;
    logic [63:0] w_in_word;
    logic [3:0]  w_idx;
    logic [3:0]  w_idx_m2;
    logic [3:0]  w_idx_m7;
    logic [3:0]  w_idx_m15;
    logic [63:0] w_s0;
    logic [63:0] w_s1;
    logic [63:0] w_sum_full;
    logic [63:0] w_sum;
    logic [63:0] w_word;
    logic [6:0]  w_last_t;
    logic        w_at_last;

    assign w_emit     = (r_state == ST_EMIT);
    assign w_in_fire  = in_valid && r_in_ready;
    assign w_out_fire = w_emit && out_ready;

    // The first word of a block is masked by the live flag; later words by the latched mode.
    assign w_mode_in  = (r_state == ST_IDLE) ? data_width_flag : r_mode;
    assign w_in_word  = w_mode_in ? in_data : {32'h0, in_data[31:0]};

    assign w_idx      = r_t[3:0];
    assign w_idx_m2   = w_idx - 4'd2;
    assign w_idx_m7   = w_idx - 4'd7;
    assign w_idx_m15  = w_idx - 4'd15;

    sha2_small_sigma #(.SIGMA1(1'b0)) u_sigma0 (
        .i_mode (r_mode),
        .i_x    (r_buf[w_idx_m15]),
        .o_y    (w_s0)
    );

    sha2_small_sigma #(.SIGMA1(1'b1)) u_sigma1 (
        .i_mode (r_mode),
        .i_x    (r_buf[w_idx_m2]),
        .o_y    (w_s1)
    );

    assign w_sum_full = w_s1 + r_buf[w_idx_m7] + w_s0 + r_buf[w_idx];
    assign w_sum      = r_mode ? w_sum_full : {32'h0, w_sum_full[31:0]};
    assign w_word     = (r_t < 7'd16) ? r_buf[w_idx] : w_sum;
    assign w_last_t   = r_mode ? LAST_512 : LAST_256;
    assign w_at_last  = (r_t == w_last_t);

    assign in_ready   = r_in_ready;
    assign out_valid  = w_emit;
    assign out_data   = w_emit ? w_word : 64'h0;
    assign out_index  = w_emit ? r_t : 7'h0;
    assign out_last   = w_emit && w_at_last;
    assign busy       = (r_state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_t        <= 7'd0;
            r_mode     <= 1'b0;
            r_in_ready <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_buf[i] <= 64'h0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_in_fire) begin
                        r_mode   <= data_width_flag;
                        r_buf[0] <= w_in_word;
                        r_cnt    <= 4'd1;
                        r_state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_in_fire) begin
                        r_buf[r_cnt] <= w_in_word;
                        r_cnt        <= r_cnt + 4'd1;
                        if (r_cnt == 4'd15) begin
                            r_state    <= ST_EMIT;
                            r_t        <= 7'd0;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                ST_EMIT: begin
                    if (w_out_fire) begin
                        if (r_t >= 7'd16) begin
                            r_buf[w_idx] <= w_sum;
                        end
                        if (w_at_last) begin
                            r_state    <= ST_IDLE;
                            r_t        <= 7'd0;
                            r_cnt      <= 4'd0;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_t <= r_t + 7'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SHA2_SCHED_PERF_EN
    logic [31:0] r_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= 32'h0;
        end else if (w_emit && !out_ready && (r_stall != 32'hFFFF_FFFF)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign stall_count = r_stall;
`endif

endmodule

// File: tb/tb_sha2_msg_sched.sv
// tb/tb_sha2_msg_sched.sv - scoreboard bench for sha2_msg_sched against a whole-block schedule model
module tb_sha2_msg_sched;

    logic        clk;
    logic        rst;
    logic        data_width_flag;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [6:0]  out_index;
    logic        out_last;
    logic        busy;
`ifdef SHA2_SCHED_PERF_EN
    logic [31:0] stall_count;
`endif

    sha2_msg_sched dut (
        .clk             (clk),
        .rst             (rst),
        .data_width_flag (data_width_flag),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_index       (out_index),
        .out_last        (out_last),
        .busy            (busy)
`ifdef SHA2_SCHED_PERF_EN
        ,
        .stall_count     (stall_count)
`endif
    );

    typedef struct packed {
        logic [63:0] data;
        logic [6:0]  idx;
        logic        last;
    } exp_t;

    exp_t        sb_q[$];
    int          n_pass;
    int          n_total;
    int          cyc;
    int          c_first;
    int          c_end;
    int          stall_model;
    int          last_idx;
    logic [63:0] seen [80];
    logic [63:0] blk [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] r32(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [63:0] r64(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    function automatic logic [31:0] ss0_32(input logic [31:0] x);
        return r32(x, 7) ^ r32(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ss1_32(input logic [31:0] x);
        return r32(x, 17) ^ r32(x, 19) ^ (x >> 10);
    endfunction
    function automatic logic [63:0] ss0_64(input logic [63:0] x);
        return r64(x, 1) ^ r64(x, 8) ^ (x >> 7);
    endfunction
    function automatic logic [63:0] ss1_64(input logic [63:0] x);
        return r64(x, 19) ^ r64(x, 61) ^ (x >> 6);
    endfunction

    // Full textbook expansion W[0..N-1] from the block, queued as expected outputs.
    task automatic push_expected(input logic [63:0] b [16], input bit m64);
        logic [63:0] w64 [80];
        logic [31:0] w32 [64];
        exp_t e;
        if (m64) begin
            for (int t = 0; t < 80; t++) begin
                if (t < 16) w64[t] = b[t];
                else w64[t] = ss1_64(w64[t-2]) + w64[t-7] + ss0_64(w64[t-15]) + w64[t-16];
                e.data = w64[t];
                e.idx  = 7'(t);
                e.last = (t == 79);
                sb_q.push_back(e);
            end
        end else begin
            for (int t = 0; t < 64; t++) begin
                if (t < 16) w32[t] = b[t][31:0];
                else w32[t] = ss1_32(w32[t-2]) + w32[t-7] + ss0_32(w32[t-15]) + w32[t-16];
                e.data = {32'h0, w32[t]};
                e.idx  = 7'(t);
                e.last = (t == 63);
                sb_q.push_back(e);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (sb_q.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_unexpected_output: index %0d data 0x%0h with empty queue", out_index, out_data);
                end else begin
                    chk("sb_data", out_data, sb_q[0].data);
                    chk("sb_index", 64'(out_index), 64'(sb_q[0].idx));
                    chk("sb_last", 64'(out_last), 64'(sb_q[0].last));
                    if (out_ready) begin
                        seen[out_index] = out_data;
                        if (out_last) last_idx = int'(out_index);
                        void'(sb_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic release_reset();
        sb_q.delete();
        stall_model = 0;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = 64'h0;
        data_width_flag = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_index", 64'(out_index), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
`ifdef SHA2_SCHED_PERF_EN
        chk("rst_stall_count", 64'(stall_count), 64'd0);
`endif
        release_reset();
    endtask

    task automatic load_block(input logic [63:0] b [16], input bit flag0, input bit flag_rest, input bit gaps);
        int guard;
        for (int i = 0; i < 80; i++) seen[i] = 64'h0;
        last_idx = -1;
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            in_valid = 1'b1;
            in_data = b[i];
            data_width_flag = (i == 0) ? flag0 : flag_rest;
            guard = 0;
            while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
            if (guard >= 50) begin
                n_total++;
                $display("FAIL load_timeout: word %0d never accepted", i);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (i == 0) begin
                c_first = cyc;
                chk("load_busy", 64'(busy), 64'd1);
            end
        end
        in_valid = 1'b0;
        in_data = {$urandom, $urandom};
        data_width_flag = 1'($urandom_range(0, 1));
        push_expected(b, flag0);
    endtask

    // ready_mode: 0 always ready, 1 random, 2 pattern 1,0,0,1 while t is in 16..20
    task automatic emit_block(input int ready_mode, input bit hold_in, input int abort_at);
        int guard;
        int k;
        bit done;
        logic [3:0] pat;
        pat = 4'b1001;
        guard = 0;
        k = 0;
        done = 1'b0;
        while (!done && guard < 1000) begin
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (out_index >= 7'd16 && out_index <= 7'd20) begin
                        out_ready = pat[k % 4];
                        k++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            if (hold_in) begin
                in_valid = 1'b1;
                in_data = {$urandom, $urandom};
                chk("gate_in_ready", 64'(in_ready), 64'd0);
            end
            if (abort_at >= 0 && int'(out_index) == abort_at && out_valid) begin
                rst = 1'b1;
                in_valid = 1'b0;
                #1;
                chk("abort_out_valid", 64'(out_valid), 64'd0);
                chk("abort_busy", 64'(busy), 64'd0);
                chk("abort_out_last", 64'(out_last), 64'd0);
`ifdef SHA2_SCHED_PERF_EN
                chk("abort_stall_count", 64'(stall_count), 64'd0);
`endif
                @(posedge clk); #1;
                release_reset();
                return;
            end
            if (!out_ready) stall_model++;
            if (out_valid && out_ready && out_last) done = 1'b1;
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_total++;
            $display("FAIL emit_timeout: no out_last handshake within %0d cycles", guard);
        end
        c_end = cyc;
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_in_ready", 64'(in_ready), 64'd1);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
`ifdef SHA2_SCHED_PERF_EN
        chk("stall_count", 64'(stall_count), 64'(stall_model));
`endif
    endtask

    task automatic make_abc(input bit m64);
        for (int i = 0; i < 16; i++) blk[i] = 64'h0;
        blk[0]  = m64 ? 64'h6162638000000000 : 64'h0000000061626380;
        blk[15] = 64'h18;
    endtask

    task automatic make_random();
        for (int i = 0; i < 16; i++) blk[i] = {$urandom, $urandom};
    endtask

    task automatic run_abc256(input string tag);
        make_abc(1'b0);
        load_block(blk, 1'b0, 1'b0, 1'b0);
        emit_block(0, 1'b0, -1);
        chk({tag, "_w16"}, seen[16], 64'h0000000061626380);
        chk({tag, "_w17"}, seen[17], 64'h00000000000F0000);
        chk({tag, "_last_idx"}, 64'(last_idx), 64'd63);
        chk({tag, "_cycles"}, 64'(c_end - c_first + 1), 64'd80);
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        stall_model = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = 64'h0;
        data_width_flag = 1'b0;

        do_reset();

        run_abc256("abc256");

        make_abc(1'b1);
        load_block(blk, 1'b1, 1'b1, 1'b0);
        emit_block(0, 1'b0, -1);
        chk("abc512_w16", seen[16], 64'h6162638000000000);
        chk("abc512_w17", seen[17], 64'h00030000000000C0);
        chk("abc512_last_idx", 64'(last_idx), 64'd79);
        chk("abc512_cycles", 64'(c_end - c_first + 1), 64'd96);

        make_random();
        load_block(blk, 1'b0, 1'b0, 1'b1);
        emit_block(2, 1'b0, -1);
        make_random();
        load_block(blk, 1'b1, 1'b1, 1'b1);
        emit_block(2, 1'b0, -1);

        make_random();
        load_block(blk, 1'b0, 1'b1, 1'b1);
        emit_block(1, 1'b0, -1);
        chk("latch_last_idx", 64'(last_idx), 64'd63);

        make_abc(1'b0);
        load_block(blk, 1'b0, 1'b0, 1'b0);
        emit_block(0, 1'b0, 30);
        chk("abort_no_last", 64'(last_idx), 64'hFFFF_FFFF_FFFF_FFFF);
        run_abc256("abc256_again");

        make_random();
        load_block(blk, 1'b1, 1'b1, 1'b0);
        emit_block(1, 1'b1, -1);
        make_random();
        load_block(blk, 1'b0, 1'b0, 1'b1);
        emit_block(1, 1'b0, -1);

        for (int n = 0; n < 4; n++) begin
            bit m;
            m = 1'($urandom_range(0, 1));
            make_random();
            load_block(blk, m, m, 1'b1);
            emit_block(1, 1'b0, -1);
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
